// File: rtl/mul_share_arb_if.sv
// Request/response bundle shared between the requesters and mul_share_arb.
//   master : requester side  - drives req_valid/req_a/req_b, sees req_ready and responses
//   slave  : arbiter side    - sees requests, drives req_ready/resp_valid/resp_p
// Operands of requester i live at [i*WIDTH +: WIDTH] of req_a / req_b.
interface mul_share_arb_if #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 8
);
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ*WIDTH-1:0] req_a;
   logic [NUM_REQ*WIDTH-1:0] req_b;
   logic [NUM_REQ-1:0]       req_ready;
   logic [NUM_REQ-1:0]       resp_valid;
   logic [2*WIDTH-1:0]       resp_p;

   modport master (
      output req_valid, req_a, req_b,
      input  req_ready, resp_valid, resp_p
   );

   modport slave (
      input  req_valid, req_a, req_b,
      output req_ready, resp_valid, resp_p
   );
endinterface

// File: rtl/mul_share_arb.sv
// Round-robin scheduler time-sharing one external combinational WIDTHxWIDTH
// multiplier among NUM_REQ requesters. One grant per cycle, operands are
// registered toward the multiplier, and the product is captured one cycle later
// and returned as a one-hot tagged pulse to the issuing requester.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   bus (slave)      requests in, combinational one-hot grant, tagged responses out
//   mul_a, mul_b     registered operands to the multiplier
//   mul_y            combinational product from the multiplier
//   busy             a multiply is in stage 1 or being presented
//   op_count         completed multiplies, wraps modulo 2^CNT_W
module mul_share_arb #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 8,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   mul_share_arb_if.slave     bus,
   output logic [WIDTH-1:0]   mul_a,
   output logic [WIDTH-1:0]   mul_b,
   input  logic [2*WIDTH-1:0] mul_y,
   output logic               busy,
   output logic [CNT_W-1:0]   op_count
);
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0] grant_s;
   logic [IDX_W-1:0]   gnt_idx_s;
   logic               gnt_any_s;
   logic [IDX_W-1:0]   idx_s;

   logic [IDX_W-1:0]   rr_ptr_r;
   logic               s1_vld_r;
   logic [IDX_W-1:0]   s1_tag_r;
   logic [WIDTH-1:0]   mul_a_r;
   logic [WIDTH-1:0]   mul_b_r;
   logic [NUM_REQ-1:0] resp_valid_r;
   logic [2*WIDTH-1:0] resp_p_r;
   logic               busy_r;
   logic [CNT_W-1:0]   op_count_r;

   // Round-robin search: first valid requester at or after rr_ptr, wrapping.
   always_comb begin
      grant_s   = '0;
      gnt_idx_s = '0;
      gnt_any_s = 1'b0;
      idx_s     = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx_s = IDX_W'((int'(rr_ptr_r) + k) % NUM_REQ);
         if (!gnt_any_s && bus.req_valid[idx_s]) begin
            gnt_any_s        = 1'b1;
            gnt_idx_s        = idx_s;
            grant_s[idx_s]   = 1'b1;
         end else begin
            gnt_any_s = gnt_any_s;
         end
      end
   end

   assign bus.req_ready  = grant_s;
   assign bus.resp_valid = resp_valid_r;
   assign bus.resp_p     = resp_p_r;
   assign mul_a          = mul_a_r;
   assign mul_b          = mul_b_r;
   assign busy           = busy_r;
   assign op_count       = op_count_r;

   // Pointer, issue stage, capture stage, busy flag and completion counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_r     <= '0;
         s1_vld_r     <= 1'b0;
         s1_tag_r     <= '0;
         mul_a_r      <= '0;
         mul_b_r      <= '0;
         resp_valid_r <= '0;
         resp_p_r     <= '0;
         busy_r       <= 1'b0;
         op_count_r   <= '0;
      end else begin
         // Issue stage: latch the winner's operands toward the multiplier.
         if (gnt_any_s) begin
            mul_a_r  <= bus.req_a[int'(gnt_idx_s)*WIDTH +: WIDTH];
            mul_b_r  <= bus.req_b[int'(gnt_idx_s)*WIDTH +: WIDTH];
            s1_tag_r <= gnt_idx_s;
            rr_ptr_r <= (gnt_idx_s == IDX_W'(NUM_REQ-1)) ? IDX_W'(0) : gnt_idx_s + IDX_W'(1);
         end else begin
            mul_a_r  <= mul_a_r;
            mul_b_r  <= mul_b_r;
            s1_tag_r <= s1_tag_r;
            rr_ptr_r <= rr_ptr_r;
         end
         s1_vld_r <= gnt_any_s;

         // Capture stage: the multiplier output settled during the cycle after issue.
         if (s1_vld_r) begin
            resp_p_r     <= mul_y;
            resp_valid_r <= NUM_REQ'(1) << s1_tag_r;
            op_count_r   <= op_count_r + CNT_W'(1);
         end else begin
            resp_p_r     <= resp_p_r;
            resp_valid_r <= '0;
            op_count_r   <= op_count_r;
         end

         // Next-state form of s1_vld | (resp_valid != 0), so busy is a flop.
         busy_r <= gnt_any_s | s1_vld_r;
      end
   end
endmodule

// File: tb/tb_mul_share_arb.sv
module tb_mul_share_arb;
   localparam int N = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mul_share_arb_if #(.NUM_REQ(N), .WIDTH(8)) bus  ();
   mul_share_arb_if #(.NUM_REQ(N), .WIDTH(8)) bus4 ();

   logic [7:0]  mul_a, mul_b, mul_a4, mul_b4;
   logic [15:0] mul_y, mul_y4, op_count;
   logic [3:0]  op_count4;
   logic        busy, busy4;

   // Behavioural stand-ins for the external multiplier.
   assign mul_y  = {8'd0, mul_a}  * {8'd0, mul_b};
   assign mul_y4 = {8'd0, mul_a4} * {8'd0, mul_b4};

   mul_share_arb #(.NUM_REQ(N), .WIDTH(8), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus.slave), .mul_a(mul_a), .mul_b(mul_b),
      .mul_y(mul_y), .busy(busy), .op_count(op_count));

   mul_share_arb #(.NUM_REQ(N), .WIDTH(8), .CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .bus(bus4.slave), .mul_a(mul_a4), .mul_b(mul_b4),
      .mul_y(mul_y4), .busy(busy4), .op_count(op_count4));

   typedef struct {int tag; int p; int exp_edge;} sb_t;
   sb_t sb[$];

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int cnt = 0;       // completed operations since last reset (reference)
   int ptr = 0;       // reference round-robin start point
   bit fair_mode = 1'b0;
   bit hold_v [N];
   int hold_a [N];
   int hold_b [N];
   int wait_c [N];
   int dir_a  [N];
   int dir_b  [N];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compares every cycle against the scoreboard head.
   always @(negedge clk) begin
      bit busy_e;
      logic [3:0] exp_rv;
      if (!rst_n) begin
         chk("rst_resp_valid", {28'd0, bus.resp_valid}, 32'd0);
         chk("rst_resp_p", {16'd0, bus.resp_p}, 32'd0);
         chk("rst_mul_a", {24'd0, mul_a}, 32'd0);
         chk("rst_mul_b", {24'd0, mul_b}, 32'd0);
         chk("rst_busy", {31'd0, busy}, 32'd0);
         chk("rst_op_count", {16'd0, op_count}, 32'd0);
         chk("rst_op_count4", {28'd0, op_count4}, 32'd0);
      end else begin
         busy_e = 1'b0;
         foreach (sb[k]) if (sb[k].exp_edge <= cyc + 1) busy_e = 1'b1;
         chk("busy", {31'd0, busy}, {31'd0, busy_e});
         chk("busy4", {31'd0, busy4}, {31'd0, busy_e});
         exp_rv = 4'd0;
         if (sb.size() > 0 && sb[0].exp_edge == cyc) begin
            sb_t e;
            e = sb.pop_front();
            exp_rv = 4'd1 << e.tag;
            cnt++;
            chk("resp_p", {16'd0, bus.resp_p}, 32'(e.p));
            chk("resp_p4", {16'd0, bus4.resp_p}, 32'(e.p));
         end
         chk("resp_valid", {28'd0, bus.resp_valid}, {28'd0, exp_rv});
         chk("resp_valid4", {28'd0, bus4.resp_valid}, {28'd0, exp_rv});
         chk("op_count", {16'd0, op_count}, 32'(cnt % 65536));
         chk("op_count4", {28'd0, op_count4}, 32'(cnt % 16));
      end
   end

   task automatic drive_bus();
      logic [N-1:0]   v;
      logic [N*8-1:0] a, b;
      v = '0; a = '0; b = '0;
      for (int i = 0; i < N; i++) begin
         v[i]       = hold_v[i];
         a[i*8 +: 8] = 8'(hold_a[i]);
         b[i*8 +: 8] = 8'(hold_b[i]);
      end
      bus.req_valid  = v; bus.req_a  = a; bus.req_b  = b;
      bus4.req_valid = v; bus4.req_a = a; bus4.req_b = b;
   endtask

   // One cycle of requester behaviour plus the reference grant decision.
   task automatic step(input logic [N-1:0] raise, input bit rnd);
      int g;
      int idx;
      logic [3:0] exp_ready;
      sb_t e;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
         if (!hold_v[i] && raise[i]) begin
            hold_v[i] = 1'b1;
            wait_c[i] = 0;
            hold_a[i] = rnd ? int'($urandom_range(0, 255)) : dir_a[i];
            hold_b[i] = rnd ? int'($urandom_range(0, 255)) : dir_b[i];
         end
      end
      drive_bus();
      #1;
      g = -1;
      for (int k = 0; k < N; k++) begin
         idx = (ptr + k) % N;
         if (g < 0 && hold_v[idx]) g = idx;
      end
      exp_ready = (g >= 0) ? (4'd1 << g) : 4'd0;
      chk("req_ready", {28'd0, bus.req_ready}, {28'd0, exp_ready});
      chk("req_ready4", {28'd0, bus4.req_ready}, {28'd0, exp_ready});
      for (int i = 0; i < N; i++) if (hold_v[i] && i != g) wait_c[i]++;
      if (g >= 0) begin
         chk("fair_wait", (wait_c[g] <= N - 1) ? 32'd1 : 32'd0, 32'd1);
         if (fair_mode && g == 3) chk("req3_latency", (wait_c[3] <= 1) ? 32'd1 : 32'd0, 32'd1);
         e.tag = g;
         e.p = hold_a[g] * hold_b[g];
         e.exp_edge = cyc + 2;
         sb.push_back(e);
         hold_v[g] = 1'b0;
         ptr = (g + 1) % N;
      end
   endtask

   task automatic clear_reqs();
      for (int i = 0; i < N; i++) begin
         hold_v[i] = 1'b0; hold_a[i] = 0; hold_b[i] = 0; wait_c[i] = 0;
      end
      drive_bus();
   endtask

   initial begin
      clear_reqs();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Single request on requester 2: 12*13 = 156.
      dir_a[2] = 12; dir_b[2] = 13;
      step(4'b0100, 1'b0);
      repeat (4) step(4'b0000, 1'b0);

      // All four requesting continuously.
      repeat (16) step(4'b1111, 1'b1);
      repeat (6) step(4'b0000, 1'b0);

      // Operand extremes.
      dir_a[0] = 255; dir_b[0] = 255;
      dir_a[1] = 0;   dir_b[1] = 200;
      dir_a[2] = 1;   dir_b[2] = 255;
      dir_a[3] = 12;  dir_b[3] = 13;
      step(4'b1111, 1'b0);
      repeat (6) step(4'b0000, 1'b0);

      // Requester 1 held continuously, requester 3 raised later.
      fair_mode = 1'b1;
      repeat (5) step(4'b0010, 1'b1);
      repeat (6) step(4'b1010, 1'b1);
      fair_mode = 1'b0;
      repeat (6) step(4'b0000, 1'b0);

      // Random traffic.
      repeat (1000) step(4'($urandom_range(0, 15)), 1'b1);
      repeat (6) step(4'b0000, 1'b0);

      // Reset asserted between the accepting edge and the capture edge.
      step(4'b0010, 1'b1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      sb.delete();
      cnt = 0;
      ptr = 0;
      clear_reqs();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (4) step(4'b0000, 1'b0);
      chk("op_count_after_reset", {16'd0, op_count}, 32'd0);

      // 17 completions: the 4-bit counter wraps to 1.
      repeat (17) step(4'b0001, 1'b1);
      repeat (4) step(4'b0000, 1'b0);
      chk("wrap_op_count4", {28'd0, op_count4}, 32'd1);
      chk("wrap_op_count", {16'd0, op_count}, 32'd17);
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
